// File: rtl/wb_arbiter_pkg.sv
// Shared writeback types and constants for the result arbiter and its users.
// Result payload, lane bit vector and the FU/port counts live here.
package C;
  localparam int XLEN         = 32;
  localparam int ID_W         = 6;
  localparam int PRD_W        = 6;
  localparam int NR_WB_PORTS  = 2;
  localparam int WB_ARB_NR_FU = 4;

  typedef logic [NR_WB_PORTS-1:0] wb_bitvector_t;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [ID_W-1:0]  id;
    logic [PRD_W-1:0] prd;
    logic [XLEN-1:0]  rdval;
  } fu_output_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// FU-result request side and bypass/writeback side of the writeback arbiter.
// master = FUs plus consumers, slave = the arbiter.
interface wb_arbiter_if
  import C::*;
#(
  parameter int NR_FU       = WB_ARB_NR_FU,
  parameter int NR_WB_PORTS = C::NR_WB_PORTS
);
  logic                              flush_i;
  fu_output_t [NR_FU-1:0]            fu_res_i;
  logic       [NR_FU-1:0]            fu_res_i_valid;
  logic       [NR_FU-1:0]            fu_res_i_ready;
  fu_output_t [NR_WB_PORTS-1:0]      bypass_o;
  wb_bitvector_t                     bypass_o_valid;
  fu_output_t [NR_WB_PORTS-1:0]      wb_o;
  wb_bitvector_t                     wb_o_valid;

  modport master (
    output flush_i, fu_res_i, fu_res_i_valid,
    input  fu_res_i_ready, bypass_o, bypass_o_valid, wb_o, wb_o_valid
  );

  modport slave (
    input  flush_i, fu_res_i, fu_res_i_valid,
    output fu_res_i_ready, bypass_o, bypass_o_valid, wb_o, wb_o_valid
  );
endinterface

// File: rtl/wb_arbiter_rr_multi_picker.sv
// Picks up to W requesters per cycle scanning round-robin from ptr; k-th pick goes to lane k.
// Purely combinational; next_ptr is one past the last pick, or ptr when nothing is picked.
module rr_multi_picker #(
  parameter int N  = 4,
  parameter int W  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1,
  parameter int LW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [N-1:0]         req,
  input  logic [PW-1:0]        ptr,
  output logic [N-1:0]         grant,
  output logic [N-1:0][LW-1:0] lane,
  output logic [PW-1:0]        next_ptr
);
  logic [PW-1:0] idx;
  logic [LW:0]   cnt;

  always_comb begin
    grant    = '0;
    lane     = '0;
    next_ptr = ptr;
    cnt      = '0;
    idx      = ptr;
    for (int k = 0; k < N; k++) begin
      if (req[idx] && (cnt < (LW+1)'(W))) begin
        grant[idx] = 1'b1;
        lane[idx]  = cnt[LW-1:0];
        cnt        = cnt + 1'b1;
        next_ptr   = (idx == PW'(N-1)) ? '0 : idx + 1'b1;
      end
      idx = (idx == PW'(N-1)) ? '0 : idx + 1'b1;
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: bypass in the grant cycle, registered wb_o one cycle later.
// WB_ARB_SKID_EN adds a 1-entry hold per FU (ready = !hold_valid); otherwise ready = grant.
module wb_arbiter
  import C::*;
#(
  parameter int NR_FU       = WB_ARB_NR_FU,
  parameter int NR_WB_PORTS = C::NR_WB_PORTS
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);
  localparam int PW = (NR_FU > 1) ? $clog2(NR_FU) : 1;
  localparam int LW = (NR_WB_PORTS > 1) ? $clog2(NR_WB_PORTS) : 1;

  logic       [NR_FU-1:0]         req;
  fu_output_t [NR_FU-1:0]         req_dat;
  logic       [NR_FU-1:0]         grant_raw;
  logic       [NR_FU-1:0]         grant;
  logic       [NR_FU-1:0][LW-1:0] lane;
  logic       [PW-1:0]            rr_ptr;
  logic       [PW-1:0]            next_ptr;

  rr_multi_picker #(
    .N (NR_FU),
    .W (NR_WB_PORTS),
    .PW(PW),
    .LW(LW)
  ) u_picker (
    .req     (req),
    .ptr     (rr_ptr),
    .grant   (grant_raw),
    .lane    (lane),
    .next_ptr(next_ptr)
  );

  // Flush and reset suppress every grant, so nothing is consumed or emitted.
  assign grant = grant_raw & ~{NR_FU{bus.flush_i | rst}};

`ifdef WB_ARB_SKID_EN
  fu_output_t [NR_FU-1:0] hold;
  logic       [NR_FU-1:0] hold_valid;

  assign req = hold_valid | bus.fu_res_i_valid;
  assign bus.fu_res_i_ready = rst ? '0 : ~hold_valid;

  always_comb begin
    req_dat = bus.fu_res_i;
    for (int i = 0; i < NR_FU; i++) begin
      if (hold_valid[i]) req_dat[i] = hold[i];
    end
  end

  // A held entry blocks its input, so a clearing hold never takes a new input in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= '0;
      hold       <= '0;
    end else if (bus.flush_i) begin
      hold_valid <= '0;
    end else begin
      for (int i = 0; i < NR_FU; i++) begin
        if (hold_valid[i]) begin
          if (grant[i]) hold_valid[i] <= 1'b0;
        end else if (bus.fu_res_i_valid[i] && !grant[i]) begin
          hold_valid[i] <= 1'b1;
          hold[i]       <= bus.fu_res_i[i];
        end
      end
    end
  end
`else
  assign req                = bus.fu_res_i_valid;
  assign req_dat            = bus.fu_res_i;
  assign bus.fu_res_i_ready = grant;
`endif

  always_comb begin
    bus.bypass_o       = '0;
    bus.bypass_o_valid = '0;
    for (int i = 0; i < NR_FU; i++) begin
      if (grant[i]) begin
        bus.bypass_o[lane[i]]       = req_dat[i];
        bus.bypass_o_valid[lane[i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wb_o       <= '0;
      bus.wb_o_valid <= '0;
      rr_ptr         <= '0;
    end else begin
      bus.wb_o       <= bus.bypass_o;
      bus.wb_o_valid <= bus.bypass_o_valid;
      if (|grant) rr_ptr <= next_ptr;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (NR_FU=4, NR_WB_PORTS=2); FUs hold valid until they see ready.
module tb_wb_arbiter;
  import C::*;

`ifdef WB_ARB_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  wb_arbiter_if #(.NR_FU(4), .NR_WB_PORTS(2)) bus ();

  wb_arbiter #(.NR_FU(4), .NR_WB_PORTS(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic put(input int f, input int id, input int prd, input logic [31:0] rdval);
    bus.fu_res_i[f].pc    = 32'h1000 + 32'(f * 4);
    bus.fu_res_i[f].id    = ID_W'(id);
    bus.fu_res_i[f].prd   = PRD_W'(prd);
    bus.fu_res_i[f].rdval = rdval;
    bus.fu_res_i_valid[f] = 1'b1;
  endtask

  // Called at the negedge: an accepted FU drops valid and scribbles its data bus.
  task automatic adv();
    logic [3:0] acc;
    acc = bus.fu_res_i_valid & bus.fu_res_i_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) begin
        bus.fu_res_i_valid[i] = 1'b0;
        bus.fu_res_i[i]       = '1;
      end
    end
  endtask

  initial begin
    n_chk              = 0;
    n_err              = 0;
    rst                = 1'b1;
    bus.flush_i        = 1'b0;
    bus.fu_res_i       = '0;
    bus.fu_res_i_valid = '0;
    put(0, 1, 5, 32'hAA);

    // Reset state with a request already pending
    @(negedge clk);
    chk("rst_wb_vld",  64'(bus.wb_o_valid), 0);
    chk("rst_wb_zero", 64'(|bus.wb_o), 0);
    chk("rst_by_vld",  64'(bus.bypass_o_valid), 0);
    chk("rst_ready",   64'(bus.fu_res_i_ready), 0);
    chk("rst_ptr",     64'(dut.rr_ptr), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // FU0 alone: same-cycle bypass, wb next cycle
    @(negedge clk);
    chk("t1_by_vld",   64'(bus.bypass_o_valid), 'b01);
    chk("t1_by0_prd",  64'(bus.bypass_o[0].prd), 5);
    chk("t1_by0_val",  64'(bus.bypass_o[0].rdval), 'hAA);
    chk("t1_rdy0",     64'(bus.fu_res_i_ready[0]), 1);
    adv();
    @(negedge clk);
    chk("t1_wb_vld",   64'(bus.wb_o_valid), 'b01);
    chk("t1_wb0_prd",  64'(bus.wb_o[0].prd), 5);
    chk("t1_wb0_val",  64'(bus.wb_o[0].rdval), 'hAA);
    chk("t1_ptr",      64'(dut.rr_ptr), 1);
    chk("t1_by_idle",  64'(bus.bypass_o_valid), 0);
    adv();

    // FU1,FU2 from ptr=1
    put(1, 2, 6, 32'h11);
    put(2, 3, 7, 32'h22);
    @(negedge clk);
    chk("tA_by_vld",   64'(bus.bypass_o_valid), 'b11);
    chk("tA_by0",      64'(bus.bypass_o[0].rdval), 'h11);
    chk("tA_by1",      64'(bus.bypass_o[1].rdval), 'h22);
    adv();
    @(negedge clk);
    chk("tA_wb1_id",   64'(bus.wb_o[1].id), 3);
    chk("tA_ptr",      64'(dut.rr_ptr), 3);
    adv();

    // FU3,FU0 from ptr=3: wrap-around
    put(3, 4, 8, 32'h33);
    put(0, 5, 9, 32'h44);
    @(negedge clk);
    chk("tB_by_vld",   64'(bus.bypass_o_valid), 'b11);
    chk("tB_by0",      64'(bus.bypass_o[0].rdval), 'h33);
    chk("tB_by1",      64'(bus.bypass_o[1].rdval), 'h44);
    adv();
    @(negedge clk);
    chk("tB_ptr",      64'(dut.rr_ptr), 1);
    chk("tB_wb0_id",   64'(bus.wb_o[0].id), 4);
    chk("tB_wb1_id",   64'(bus.wb_o[1].id), 5);
    adv();

    // FU3 only: lane1 stays invalid, ptr wraps to 0
    put(3, 6, 10, 32'h55);
    @(negedge clk);
    chk("tC_by_vld",   64'(bus.bypass_o_valid), 'b01);
    chk("tC_by0",      64'(bus.bypass_o[0].rdval), 'h55);
    adv();
    @(negedge clk);
    chk("tC_ptr",      64'(dut.rr_ptr), 0);
    adv();

    // All four from ptr=0
    put(0, 7, 11, 32'h60);
    put(1, 8, 12, 32'h61);
    put(2, 9, 13, 32'h62);
    put(3, 10, 14, 32'h63);
    @(negedge clk);
    chk("tD1_by0",     64'(bus.bypass_o[0].rdval), 'h60);
    chk("tD1_by1",     64'(bus.bypass_o[1].rdval), 'h61);
    chk("tD1_ready",   64'(bus.fu_res_i_ready), SKID ? 'b1111 : 'b0011);
    adv();
    @(negedge clk);
    chk("tD2_by_vld",  64'(bus.bypass_o_valid), 'b11);
    chk("tD2_by0",     64'(bus.bypass_o[0].rdval), 'h62);
    chk("tD2_by1",     64'(bus.bypass_o[1].rdval), 'h63);
    chk("tD2_ready",   64'(bus.fu_res_i_ready), SKID ? 'b0011 : 'b1100);
    chk("tD2_wb0",     64'(bus.wb_o[0].rdval), 'h60);
    adv();
    @(negedge clk);
    chk("tD3_wb0",     64'(bus.wb_o[0].rdval), 'h62);
    chk("tD3_wb1",     64'(bus.wb_o[1].rdval), 'h63);
    chk("tD3_ready",   64'(bus.fu_res_i_ready), SKID ? 'b1111 : 'b0000);
    chk("tD3_ptr",     64'(dut.rr_ptr), 0);
    adv();

    // Flush with FU2/FU3 pending and wb_o occupied
    put(0, 11, 15, 32'h70);
    put(1, 12, 16, 32'h71);
    put(2, 13, 17, 32'h72);
    put(3, 14, 18, 32'h73);
    @(negedge clk);
    chk("tE1_by0",     64'(bus.bypass_o[0].rdval), 'h70);
    adv();
    bus.flush_i = 1'b1;
    @(negedge clk);
    chk("tE2_by_vld",  64'(bus.bypass_o_valid), 0);
    chk("tE2_wb_vld",  64'(bus.wb_o_valid), 'b11);
    chk("tE2_ready",   64'(bus.fu_res_i_ready), SKID ? 'b0011 : 'b0000);
    adv();
    bus.flush_i        = 1'b0;
    bus.fu_res_i_valid = '0;
    @(negedge clk);
    chk("tE3_wb_vld",  64'(bus.wb_o_valid), 0);
    chk("tE3_by_vld",  64'(bus.bypass_o_valid), 0);
    chk("tE3_ready",   64'(bus.fu_res_i_ready), SKID ? 'b1111 : 'b0000);
    chk("tE3_ptr",     64'(dut.rr_ptr), 2);
    adv();

    // FU0..FU2 from ptr=2, then reset pulse before FU1 is served
    put(0, 15, 20, 32'h80);
    put(1, 16, 21, 32'h81);
    put(2, 17, 22, 32'h82);
    @(negedge clk);
    chk("tF1_by0",     64'(bus.bypass_o[0].rdval), 'h82);
    chk("tF1_by1",     64'(bus.bypass_o[1].rdval), 'h80);
    chk("tF1_ready",   64'(bus.fu_res_i_ready), SKID ? 'b1111 : 'b0101);
    adv();
    rst                = 1'b1;
    bus.fu_res_i_valid = '0;
    @(negedge clk);
    chk("tF2_wb_vld",  64'(bus.wb_o_valid), 0);
    chk("tF2_by_vld",  64'(bus.bypass_o_valid), 0);
    chk("tF2_ready",   64'(bus.fu_res_i_ready), 0);
    chk("tF2_ptr",     64'(dut.rr_ptr), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("tF3_wb_vld",  64'(bus.wb_o_valid), 0);
    chk("tF3_ready",   64'(bus.fu_res_i_ready), SKID ? 'b1111 : 'b0000);
    adv();
    put(1, 18, 23, 32'h90);
    put(0, 19, 24, 32'h91);
    @(negedge clk);
    chk("tF4_by0",     64'(bus.bypass_o[0].rdval), 'h91);
    chk("tF4_by1",     64'(bus.bypass_o[1].rdval), 'h90);
    adv();
    @(negedge clk);
    chk("tF5_ptr",     64'(dut.rr_ptr), 2);
    chk("tF5_wb0_id",  64'(bus.wb_o[0].id), 19);
    adv();

    // Three requesters: the loser is served next cycle with its original data
    put(0, 20, 25, 32'hA0);
    put(1, 21, 26, 32'hA1);
    put(2, 22, 27, 32'hA2);
    @(negedge clk);
    chk("tG1_by0",     64'(bus.bypass_o[0].rdval), 'hA2);
    chk("tG1_by1",     64'(bus.bypass_o[1].rdval), 'hA0);
    chk("tG1_ready",   64'(bus.fu_res_i_ready), SKID ? 'b1111 : 'b0101);
    adv();
    @(negedge clk);
    chk("tG2_by_vld",  64'(bus.bypass_o_valid), 'b01);
    chk("tG2_by0",     64'(bus.bypass_o[0].rdval), 'hA1);
    chk("tG2_by0_id",  64'(bus.bypass_o[0].id), 21);
    chk("tG2_ready",   64'(bus.fu_res_i_ready), SKID ? 'b1101 : 'b0010);
    adv();
    @(negedge clk);
    chk("tG3_wb0",     64'(bus.wb_o[0].rdval), 'hA1);
    chk("tG3_ptr",     64'(dut.rr_ptr), 2);
    chk("tG3_by_vld",  64'(bus.bypass_o_valid), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
